// File: rtl/bdma_pkg.sv
// Shared encodings for the byte-DMA load engine: transfer types, FSM states,
// and the number of bytes that make up one internal word of each type.
package bdma_pkg;

  typedef enum logic [1:0] {
    BT_PM24 = 2'b00,
    BT_DM16 = 2'b01,
    BT_DM8M = 2'b10,
    BT_DM8L = 2'b11
  } btype_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_STEAL = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] BPW_PM24 = 2'd3;
  localparam logic [1:0] BPW_DM16 = 2'd2;
  localparam logic [1:0] BPW_DM8  = 2'd1;

  function automatic logic [1:0] bytes_per_word(input btype_e t);
    case (t)
      BT_PM24: return BPW_PM24;
      BT_DM16: return BPW_DM16;
      default: return BPW_DM8;
    endcase
  endfunction

endpackage

// File: rtl/bdma_byte_packer.sv
// Byte counter and lane placement: assembles incoming bytes into the 24-bit
// word buffer according to the transfer type.
module bdma_byte_packer
  import bdma_pkg::*;
(
  input  logic        DSPCLK,
  input  logic        RST,
  input  logic        start,
  input  logic        word_wr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  input  btype_e      btype,
  output logic [23:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [1:0]  lane;
  logic [23:0] placed;

  // lane 2 = [23:16], lane 1 = [15:8], lane 0 = [7:0]; first byte of a word
  // starts from a cleared buffer so stale bytes never leak into the next word
  always_comb begin
    lane = 2'd0;
    case (btype)
      BT_PM24: lane = 2'd2 - byte_cnt;
      BT_DM16: lane = 2'd1 - byte_cnt;
      BT_DM8M: lane = 2'd1;
      default: lane = 2'd0;
    endcase
    placed = (byte_cnt == 2'd0) ? 24'h000000 : word;
    case (lane)
      2'd2:    placed[23:16] = byte_in;
      2'd1:    placed[15:8]  = byte_in;
      default: placed[7:0]   = byte_in;
    endcase
  end

  assign word_done = byte_vld && (byte_cnt == (bytes_per_word(btype) - 2'd1));

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      byte_cnt <= 2'd0;
      word     <= 24'h000000;
    end else if (start) begin
      byte_cnt <= 2'd0;
      word     <= 24'h000000;
    end else if (word_wr) begin
      byte_cnt <= 2'd0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= placed;
    end
  end

endmodule

// File: rtl/bdma_pack.sv
// Byte-DMA load engine: fetches bytes, packs them into PM/DM words and writes
// each word during a stolen internal bus cycle.
//
//   state | meaning
//   IDLE  | waiting for ldBDMA
//   FETCH | requesting bytes until a full word is packed
//   STEAL | requesting a bus cycle from the sequencer
//   WRITE | driving the packed word with PMD/DMD output enable
//   DONE  | one-cycle completion interrupt
module bdma_pack
  import bdma_pkg::*;
#(
  parameter int AW = 14,
  parameter int CW = 14
) (
  input  logic          DSPCLK,
  input  logic          RST,
  input  logic          ldBDMA,
  input  logic [1:0]    BTYPE,
  input  logic [AW-1:0] BIAD_ld,
  input  logic [CW-1:0] BWCOUNT_ld,
  output logic          BM_req,
  input  logic          BM_vld,
  input  logic [7:0]    BM_byte,
  output logic          BSTEAL_req,
  input  logic          BSTEAL_gnt,
  output logic [23:0]   BRdataBUF,
  output logic          bdmaPMD_oe,
  output logic          bdmaDMD_oe,
  output logic [AW-1:0] BIAD,
  output logic [CW-1:0] BWCOUNT,
  output logic          BDMA_busy,
  output logic          BDMA_irq
);

  state_e state, state_nxt;
  btype_e btype_q;
  logic   start, byte_vld, word_wr, word_done;

  assign start    = (state == S_IDLE) && ldBDMA;
  assign byte_vld = (state == S_FETCH) && BM_vld;
  assign word_wr  = (state == S_WRITE);

  bdma_byte_packer u_packer (
    .DSPCLK    (DSPCLK),
    .RST       (RST),
    .start     (start),
    .word_wr   (word_wr),
    .byte_vld  (byte_vld),
    .byte_in   (BM_byte),
    .btype     (btype_q),
    .word      (BRdataBUF),
    .word_done (word_done)
  );

  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      state   <= S_IDLE;
      btype_q <= BT_PM24;
      BIAD    <= '0;
      BWCOUNT <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        btype_q <= btype_e'(BTYPE);
        BIAD    <= BIAD_ld;
        BWCOUNT <= BWCOUNT_ld;
      end else if (word_wr) begin
        BIAD    <= BIAD + AW'(1);
        BWCOUNT <= BWCOUNT - CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    BM_req     = 1'b0;
    BSTEAL_req = 1'b0;
    bdmaPMD_oe = 1'b0;
    bdmaDMD_oe = 1'b0;
    BDMA_busy  = 1'b0;
    BDMA_irq   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ldBDMA) state_nxt = (BWCOUNT_ld == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        BDMA_busy = 1'b1;
        // the returning byte's cycle is a gap so only one byte is ever outstanding
        BM_req    = !BM_vld;
        if (word_done) state_nxt = S_STEAL;
      end
      S_STEAL: begin
        BDMA_busy  = 1'b1;
        BSTEAL_req = 1'b1;
        if (BSTEAL_gnt) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        BDMA_busy  = 1'b1;
        bdmaPMD_oe = (btype_q == BT_PM24);
        bdmaDMD_oe = (btype_q != BT_PM24);
        state_nxt  = (BWCOUNT == CW'(1)) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        BDMA_irq  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bdma_pack.sv
// Self-checking bench for bdma_pack: directed and randomized transfers with a
// byte-memory responder, a grant generator and a word-level reference model.
module tb_bdma_pack;

  localparam int AW = 14;
  localparam int CW = 14;

  logic          DSPCLK = 1'b0;
  logic          RST = 1'b1;
  logic          ldBDMA = 1'b0;
  logic [1:0]    BTYPE = 2'b00;
  logic [AW-1:0] BIAD_ld = '0;
  logic [CW-1:0] BWCOUNT_ld = '0;
  logic          BM_req;
  logic          BM_vld = 1'b0;
  logic [7:0]    BM_byte = 8'h00;
  logic          BSTEAL_req;
  logic          BSTEAL_gnt = 1'b0;
  logic [23:0]   BRdataBUF;
  logic          bdmaPMD_oe, bdmaDMD_oe;
  logic [AW-1:0] BIAD;
  logic [CW-1:0] BWCOUNT;
  logic          BDMA_busy, BDMA_irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] byte_src[$];
  bit outst, nv;
  int dly;

  bdma_pack #(.AW(AW), .CW(CW)) dut (
    .DSPCLK(DSPCLK), .RST(RST), .ldBDMA(ldBDMA), .BTYPE(BTYPE),
    .BIAD_ld(BIAD_ld), .BWCOUNT_ld(BWCOUNT_ld), .BM_req(BM_req),
    .BM_vld(BM_vld), .BM_byte(BM_byte), .BSTEAL_req(BSTEAL_req),
    .BSTEAL_gnt(BSTEAL_gnt), .BRdataBUF(BRdataBUF), .bdmaPMD_oe(bdmaPMD_oe),
    .bdmaDMD_oe(bdmaDMD_oe), .BIAD(BIAD), .BWCOUNT(BWCOUNT),
    .BDMA_busy(BDMA_busy), .BDMA_irq(BDMA_irq)
  );

  always #5 DSPCLK = ~DSPCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bpw(input int t);
    return (t == 0) ? 3 : (t == 1) ? 2 : 1;
  endfunction

  // word value = sum of byte * 256^lane, lanes taken from the type's layout
  function automatic int exp_word(input int t, input int b0, input int b1, input int b2);
    case (t)
      0:       return b0 * 65536 + b1 * 256 + b2;
      1:       return b0 * 256 + b1;
      2:       return b0 * 256;
      default: return b0;
    endcase
  endfunction

  // byte memory responder: one request in flight, answers 1..3 cycles later
  task automatic mem_update(input bit zw);
    if (BM_vld) outst = 0;
    if (BM_req && !outst) begin
      outst = 1;
      dly   = zw ? 1 : int'($urandom_range(1, 3));
    end
    nv = 0;
    if (outst) begin
      if (dly <= 1) nv = 1;
      else dly--;
    end
  endtask

  task automatic run_xfer(input int t, input int addr, input int cnt, input int hold,
                          input bit zw, input bit ld_busy, input bit ld_done);
    int cyc = 0, words = 0, irqs = 0, irq_cyc = -100, oe_cyc = -100, gnt_cyc = -100;
    int stall = 0, stall_low = 0, reqs = 0, steals = 0;
    int bw = bpw(t);
    int per_word = 2 * bw + 2 + hold;
    bit stray = 0, ld_next = 0;
    logic [7:0] wb[$];
    logic [7:0] b;
    logic [23:0] last_word = 24'h0;

    outst = 0; nv = 0; dly = 0;
    @(posedge DSPCLK); #1;
    ldBDMA = 1; BTYPE = t[1:0]; BIAD_ld = addr[AW-1:0]; BWCOUNT_ld = cnt[CW-1:0];
    BM_vld = 0; BSTEAL_gnt = (hold == 0);
    @(negedge DSPCLK);
    ld_next = ld_done && (cnt == 0);

    while (cyc < 3000 && !(irqs > 0 && cyc >= irq_cyc + 3)) begin
      cyc++;
      @(posedge DSPCLK); #1;
      ldBDMA = 0;
      if (ld_busy && cyc == 3) begin
        ldBDMA = 1; BTYPE = ~t[1:0]; BIAD_ld = 14'h1555; BWCOUNT_ld = 14'd5;
      end
      if (ld_next) begin
        ldBDMA = 1; BTYPE = 2'b01; BIAD_ld = 14'h0AAA; BWCOUNT_ld = 14'd7;
        ld_next = 0;
      end
      BM_vld = nv | stray;
      BM_byte = 8'($urandom);
      if (nv) begin
        if (byte_src.size() > 0) b = byte_src.pop_front();
        else b = 8'($urandom);
        BM_byte = b;
        wb.push_back(b);
      end
      stray = 0;
      BSTEAL_gnt = (stall >= hold);
      @(negedge DSPCLK);

      if (BM_vld) chk("bm_req_drop", BM_req, 0);
      if (BM_req) reqs++;
      if (BSTEAL_req) steals++;
      if (BSTEAL_req && BSTEAL_gnt) gnt_cyc = cyc;
      if (bdmaPMD_oe || bdmaDMD_oe) begin
        chk("oe_type", {bdmaPMD_oe, bdmaDMD_oe}, (t == 0) ? 2'b10 : 2'b01);
        chk("word_bytes", wb.size(), bw);
        chk("word_data", BRdataBUF, exp_word(t, (wb.size() > 0) ? int'(wb[0]) : 0,
                                                (wb.size() > 1) ? int'(wb[1]) : 0,
                                                (wb.size() > 2) ? int'(wb[2]) : 0));
        chk("word_addr", BIAD, (addr + words) % (1 << AW));
        chk("word_count", BWCOUNT, cnt - words);
        chk("steal_wait", stall_low, hold);
        chk("oe_after_gnt", cyc, gnt_cyc + 1);
        if (zw) chk("oe_latency", cyc, (words + 1) * per_word);
        last_word = BRdataBUF;
        words++;
        wb.delete();
        stall = 0; stall_low = 0;
        oe_cyc = cyc;
        if (ld_done && words == cnt) ld_next = 1;
      end else if (cyc == oe_cyc + 1) begin
        chk("buf_hold", BRdataBUF, last_word);
      end
      if (BDMA_irq) begin
        irqs++;
        irq_cyc = cyc;
        chk("irq_words", words, cnt);
        if (cnt > 0) chk("irq_after_oe", cyc, oe_cyc + 1);
        if (zw || cnt == 0) chk("irq_latency", cyc, cnt * per_word + 1);
      end else if (irqs > 0) begin
        chk("idle_after", {BDMA_busy, BM_req, BSTEAL_req, bdmaPMD_oe, bdmaDMD_oe}, 0);
      end
      if (BSTEAL_req) begin
        if (!BSTEAL_gnt) stall_low++;
        stall++;
        if (!outst && $urandom_range(0, 3) == 0) stray = 1;
      end
      mem_update(zw);
    end

    @(posedge DSPCLK); #1;
    ldBDMA = 0; BM_vld = 0; BSTEAL_gnt = 0;
    chk("irq_count", irqs, 1);
    chk("oe_count", words, cnt);
    chk("final_addr", BIAD, (addr + cnt) % (1 << AW));
    chk("final_count", BWCOUNT, 0);
    if (cnt == 0) chk("zero_no_activity", reqs + steals, 0);
  endtask

  initial begin
    int t, a, c, h;
    bit z, lb, ld;
    bit seen;

    repeat (3) @(posedge DSPCLK);
    @(negedge DSPCLK);
    chk("reset_ctl", {BM_req, BSTEAL_req, bdmaPMD_oe, bdmaDMD_oe, BDMA_busy, BDMA_irq}, 0);
    chk("reset_buf", BRdataBUF, 0);
    chk("reset_addr_count", {BIAD, BWCOUNT}, 0);
    @(posedge DSPCLK); #1 RST = 0;

    byte_src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_xfer(0, 'h0100, 2, 0, 1, 0, 0);
    byte_src = '{8'hAB, 8'hCD};
    run_xfer(1, 'h0040, 1, 5, 1, 0, 0);
    byte_src = '{8'h5A};
    run_xfer(2, 'h0007, 1, 0, 1, 0, 0);
    byte_src = '{8'h5A};
    run_xfer(3, 'h0008, 1, 0, 1, 0, 0);
    run_xfer(0, 'h0123, 0, 0, 1, 0, 0);
    run_xfer(3, 'h3FFF, 2, 0, 1, 0, 1);

    // abort while waiting for a grant
    outst = 0; nv = 0;
    @(posedge DSPCLK); #1;
    ldBDMA = 1; BTYPE = 2'b00; BIAD_ld = 14'h0200; BWCOUNT_ld = 14'd3; BSTEAL_gnt = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge DSPCLK); #1;
      ldBDMA = 0; BM_vld = nv; BM_byte = 8'($urandom);
      @(negedge DSPCLK);
      if (BSTEAL_req) seen = 1;
      mem_update(1);
    end
    chk("reach_steal", seen, 1);
    @(posedge DSPCLK); #1 RST = 1; BM_vld = 0;
    @(posedge DSPCLK); #1 RST = 0;
    @(negedge DSPCLK);
    chk("abort_ctl", {BM_req, BSTEAL_req, bdmaPMD_oe, bdmaDMD_oe, BDMA_busy, BDMA_irq}, 0);
    chk("abort_data", {BRdataBUF, BIAD, BWCOUNT}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge DSPCLK);
      chk("abort_quiet", {BDMA_irq, BDMA_busy, bdmaPMD_oe, bdmaDMD_oe}, 0);
    end
    run_xfer(1, 'h0010, 3, 1, 0, 1, 0);

    for (int k = 0; k < 8; k++) begin
      t  = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 16383));
      c  = int'($urandom_range(0, 4));
      h  = int'($urandom_range(0, 3));
      z  = 1'($urandom_range(0, 1));
      lb = (c > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      ld = 1'($urandom_range(0, 1));
      run_xfer(t, a, c, h, z, lb, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
